// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM encoding, default
// vector layout and the source-address to vector mapping.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int unsigned VEC_BASE_DEF   = 32'h20;
    localparam int unsigned VEC_STRIDE_DEF = 32'd4;

    // 32-bit arithmetic; the caller truncates to its vector width, so the
    // result wraps modulo 2**VEC_W.
    function automatic int unsigned addr_to_vec(input int unsigned addr,
                                                input int unsigned base,
                                                input int unsigned stride);
        return base + addr * stride;
    endfunction

endpackage

// File: rtl/irq_fifo.sv
// Small synchronous FIFO with show-ahead read data. A push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module irq_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Queues interrupt events from the controller and hands them to the CPU one at
// a time through a req/ack handshake followed by an end-of-interrupt.
//
// state   | meaning
// IDLE    | nothing in flight; pops the FIFO and loads the vector when non-empty
// REQ     | vector presented, cpu_irq_req asserted, waiting for ack
// SERVICE | acknowledged, busy asserted, waiting for EOI
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int          ADDR_W     = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter int          VEC_W      = 8,
    parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              int_in,
    input  logic [ADDR_W-1:0]                 irq_addr_in,
    output logic                              cpu_irq_req,
    output logic [VEC_W-1:0]                  cpu_irq_vector,
    input  logic                              cpu_irq_ack,
    input  logic                              cpu_eoi,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_cnt,
    output logic                              overflow,
    input  logic                              clr_overflow
);

    irq_state_e         state_q, state_d;
    logic               int_q;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic               evt;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADDR_W-1:0]  fifo_rdata;

    assign evt      = int_in & ~int_q;
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    irq_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (evt),
        .pop   (fifo_pop),
        .wdata (irq_addr_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_cnt)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (evt && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // req rises one cycle after entering REQ; ack is only honoured once the
    // CPU can actually have seen the request.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        busy_d  = busy_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                req_d  = 1'b0;
                busy_d = 1'b0;
                if (fifo_pop) begin
                    vec_d   = VEC_W'(addr_to_vec(32'(fifo_rdata), VEC_BASE, VEC_STRIDE));
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                busy_d = 1'b0;
                if (req_q && cpu_irq_ack) begin
                    state_d = ST_SERVICE;
                    req_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                req_d  = 1'b0;
                busy_d = 1'b1;
                if (cpu_eoi) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            int_q   <= int_in;
            req_q   <= req_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            vec_q   <= vec_d;
        end
    end

    assign cpu_irq_req    = req_q;
    assign busy           = busy_q;
    assign cpu_irq_vector = vec_q;
    assign overflow       = ovf_q;

endmodule
